bcd_stopwatch_lapfifo: RTL and testbench

Second-generation BCD stopwatch core: hh:mm:ss (six BCD digits) with a built-in tick prescaler and selectable count-up or count-down (timer) mode. Lap captures go into a parametrised show-ahead FIFO, read out by a simple pop handshake. It drives the existing seven-segment decoder layer and replaces the single-lap hh:mm core.

---
 rtl/bcd_stopwatch_lapfifo_if.sv | 40 ++++
 rtl/bcd_stopwatch_lapfifo.sv | 242 ++++++++++++++++++++++++
 tb/tb_bcd_stopwatch_lapfifo.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_lapfifo_if.sv
// Purpose : bundles the command, count and lap-FIFO signals of the BCD
//           stopwatch core into one interface.
// Modports: master - drives commands and pops laps, observes status
//           slave  - the stopwatch core itself
// Signals : start/stop/lap/clr/load/load_val/mode_down  commands
//           cnt/state/done                              counter status
//           lap_rd_en/lap_rd_data/lap_count/lap_empty/
//           lap_full/lap_ovf                            lap FIFO read side
interface bcd_stopwatch_lapfifo_if #(
   parameter int LAP_DEPTH = 8
);
   localparam int CNT_W = $clog2(LAP_DEPTH + 1);

   logic             start;
   logic             stop;
   logic             lap;
   logic             clr;
   logic             load;
   logic [23:0]      load_val;
   logic             mode_down;
   logic [23:0]      cnt;
   logic [1:0]       state;
   logic             done;
   logic             lap_rd_en;
   logic [23:0]      lap_rd_data;
   logic [CNT_W-1:0] lap_count;
   logic             lap_empty;
   logic             lap_full;
   logic             lap_ovf;

   modport master (
      output start, stop, lap, clr, load, load_val, mode_down, lap_rd_en,
      input  cnt, state, done, lap_rd_data, lap_count, lap_empty, lap_full, lap_ovf
   );

   modport slave (
      input  start, stop, lap, clr, load, load_val, mode_down, lap_rd_en,
      output cnt, state, done, lap_rd_data, lap_count, lap_empty, lap_full, lap_ovf
   );
endinterface

// File: rtl/bcd_stopwatch_lapfifo.sv
// Purpose : hh:mm:ss BCD stopwatch / countdown timer with a tick prescaler
//           and a show-ahead lap FIFO.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - bcd_stopwatch_lapfifo_if.slave (commands, count, status,
//                   lap FIFO pop handshake). Every output is a flop.
// Params  : TICK_DIV  - clk cycles per one-second tick (>=1)
//           LAP_DEPTH - lap FIFO entries (power of two, >=2)
module bcd_stopwatch_lapfifo #(
   parameter int TICK_DIV  = 50000000,
   parameter int LAP_DEPTH = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   bcd_stopwatch_lapfifo_if.slave  bus
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PTR_W = $clog2(LAP_DEPTH);
   localparam int CNT_W = $clog2(LAP_DEPTH + 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LAP_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STOP = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [23:0]      cnt_q, cnt_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic             done_q, done_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, full_q;
   logic             ovf_q, ovf_d;
   logic [23:0]      head_q, head_d;
   logic [23:0]      mem_q [LAP_DEPTH];

   logic             tick;
   logic             load_ok;
   logic             push_req;
   logic             push_ok;
   logic             pop_ok;

   // BCD +1 second with carries; 23:59:59 wraps to 00:00:00.
   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;
      {h_t, h_o, m_t, m_o, s_t, s_o} = v;
      if (s_o != 4'd9) s_o = s_o + 4'd1;
      else begin
         s_o = 4'd0;
         if (s_t != 4'd5) s_t = s_t + 4'd1;
         else begin
            s_t = 4'd0;
            if (m_o != 4'd9) m_o = m_o + 4'd1;
            else begin
               m_o = 4'd0;
               if (m_t != 4'd5) m_t = m_t + 4'd1;
               else begin
                  m_t = 4'd0;
                  if (h_t == 4'd2 && h_o == 4'd3) begin
                     h_t = 4'd0;
                     h_o = 4'd0;
                  end else if (h_o == 4'd9) begin
                     h_o = 4'd0;
                     h_t = h_t + 4'd1;
                  end else begin
                     h_o = h_o + 4'd1;
                  end
               end
            end
         end
      end
      return {h_t, h_o, m_t, m_o, s_t, s_o};
   endfunction

   // BCD -1 second with borrows. Never called with 00:00:00, so the hour
   // borrow always has something to take from.
   function automatic logic [23:0] bcd_dec(input logic [23:0] v);
      logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;
      {h_t, h_o, m_t, m_o, s_t, s_o} = v;
      if (s_o != 4'd0) s_o = s_o - 4'd1;
      else begin
         s_o = 4'd9;
         if (s_t != 4'd0) s_t = s_t - 4'd1;
         else begin
            s_t = 4'd5;
            if (m_o != 4'd0) m_o = m_o - 4'd1;
            else begin
               m_o = 4'd9;
               if (m_t != 4'd0) m_t = m_t - 4'd1;
               else begin
                  m_t = 4'd5;
                  if (h_o != 4'd0) h_o = h_o - 4'd1;
                  else begin
                     h_o = 4'd9;
                     h_t = h_t - 4'd1;
                  end
               end
            end
         end
      end
      return {h_t, h_o, m_t, m_o, s_t, s_o};
   endfunction

   // A load is only meaningful if every digit is in range and hours <= 23.
   assign load_ok = ((bus.load_val[23:20] <  4'd2 && bus.load_val[19:16] <= 4'd9) ||
                     (bus.load_val[23:20] == 4'd2 && bus.load_val[19:16] <= 4'd3)) &&
                    bus.load_val[15:12] <= 4'd5 && bus.load_val[11:8] <= 4'd9 &&
                    bus.load_val[7:4]   <= 4'd5 && bus.load_val[3:0]  <= 4'd9;

   assign tick = (state_q == ST_RUN) && (presc_q == PRE_MAX);

   // Next-state for the counter FSM and the lap FIFO bookkeeping.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      presc_d  = presc_q;
      done_d   = done_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      push_req = 1'b0;
      push_ok  = 1'b0;
      pop_ok   = 1'b0;

      if (bus.clr) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         presc_d  = '0;
         done_d   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         // A rejected load falls through so stop/start still act that cycle.
         if (bus.load && state_q != ST_RUN && load_ok) begin
            cnt_d   = bus.load_val;
            presc_d = '0;
            done_d  = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  presc_d = '0;
                  if (bus.start && !bus.stop) state_d = ST_RUN;
               end
               ST_RUN: begin
                  if (tick) begin
                     presc_d = '0;
                     if (!bus.mode_down) begin
                        cnt_d = bcd_inc(cnt_q);
                     end else if (cnt_q == 24'h0) begin
                        done_d  = 1'b1;
                        state_d = ST_STOP;
                     end else begin
                        cnt_d = bcd_dec(cnt_q);
                     end
                  end else begin
                     presc_d = presc_q + PRE_W'(1);
                  end
                  if (bus.stop) state_d = ST_STOP;
               end
               ST_STOP: begin
                  if (bus.start && !bus.stop) begin
                     state_d = ST_RUN;
                     done_d  = 1'b0;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end

         // A full FIFO still accepts a push when the head is popped alongside.
         push_req = bus.lap && (state_q != ST_IDLE);
         pop_ok   = bus.lap_rd_en && (count_q != '0);
         push_ok  = push_req && ((count_q != DEPTH_C) || pop_ok);
         if (push_req && !push_ok) ovf_d = 1'b1;
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      // Registered show-ahead head: bypass the incoming word when it becomes
      // the only entry, since the memory write lands on the same edge.
      if (count_d == '0)              head_d = '0;
      else if (push_ok && count_d == CNT_W'(1)) head_d = cnt_q;
      else                            head_d = mem_q[rd_ptr_d];
   end

   // Control and status flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         presc_q  <= '0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         head_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= (count_d == '0);
         full_q   <= (count_d == DEPTH_C);
         ovf_q    <= ovf_d;
         head_q   <= head_d;
      end
   end

   // Lap storage needs no reset: it is only read while count_q is nonzero.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= cnt_q;
   end

   assign bus.cnt         = cnt_q;
   assign bus.state       = state_q;
   assign bus.done        = done_q;
   assign bus.lap_rd_data = head_q;
   assign bus.lap_count   = count_q;
   assign bus.lap_empty   = empty_q;
   assign bus.lap_full    = full_q;
   assign bus.lap_ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_lapfifo.sv
// Purpose : self-checking bench for bcd_stopwatch_lapfifo with TICK_DIV=4
//           and LAP_DEPTH=4. Stimulus queues expected status values and
//           expected lap words; a negedge monitor pops and compares them.
module tb_bcd_stopwatch_lapfifo;

   localparam int TICK_DIV  = 4;
   localparam int LAP_DEPTH = 4;

   localparam logic [5:0] C_START = 6'b000001;
   localparam logic [5:0] C_STOP  = 6'b000010;
   localparam logic [5:0] C_LAP   = 6'b000100;
   localparam logic [5:0] C_CLR   = 6'b001000;
   localparam logic [5:0] C_LOAD  = 6'b010000;
   localparam logic [5:0] C_POP   = 6'b100000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bcd_stopwatch_lapfifo_if #(.LAP_DEPTH(LAP_DEPTH)) bus ();

   bcd_stopwatch_lapfifo #(
      .TICK_DIV  (TICK_DIV),
      .LAP_DEPTH (LAP_DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef enum int {S_CNT, S_STATE, S_DONE, S_COUNT, S_EMPTY, S_FULL, S_OVF, S_RDATA, S_LAPQ} sel_e;

   typedef struct {
      string       name;
      sel_e        sel;
      logic [31:0] exp;
   } chk_t;

   chk_t        chk_q[$];
   logic [23:0] lap_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] actual(input sel_e s);
      case (s)
         S_CNT:   return 32'(bus.cnt);
         S_STATE: return 32'(bus.state);
         S_DONE:  return 32'(bus.done);
         S_COUNT: return 32'(bus.lap_count);
         S_EMPTY: return 32'(bus.lap_empty);
         S_FULL:  return 32'(bus.lap_full);
         S_OVF:   return 32'(bus.lap_ovf);
         S_RDATA: return 32'(bus.lap_rd_data);
         default: return 32'(lap_q.size());
      endcase
   endfunction

   task automatic checkOutput(input string name, input sel_e sel, input logic [31:0] exp);
      chk_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      chk_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the selected commands for exactly one clock edge.
   task automatic applyStimulus(input logic [5:0] cmd, input logic [23:0] lv);
      bus.start     = cmd[0];
      bus.stop      = cmd[1];
      bus.lap       = cmd[2];
      bus.clr       = cmd[3];
      bus.load      = cmd[4];
      bus.lap_rd_en = cmd[5];
      bus.load_val  = lv;
      step(1);
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.lap       = 1'b0;
      bus.clr       = 1'b0;
      bus.load      = 1'b0;
      bus.lap_rd_en = 1'b0;
   endtask

   // Monitor: drains queued status checks and scores every accepted pop.
   chk_t        mon_e;
   logic [31:0] mon_a;
   logic [23:0] mon_exp;
   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         mon_e = chk_q.pop_front();
         mon_a = actual(mon_e.sel);
         checks++;
         if (mon_a !== mon_e.exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", mon_e.name, mon_a, mon_e.exp);
         end
      end
      if (rst_n && bus.lap_rd_en && !bus.lap_empty) begin
         checks++;
         if (lap_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL lap_pop: got %0h expected no entry", bus.lap_rd_data);
         end else begin
            mon_exp = lap_q.pop_front();
            if (bus.lap_rd_data !== mon_exp) begin
               errors++;
               $display("[TB] FAIL lap_pop: got %0h expected %0h", bus.lap_rd_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.lap       = 1'b0;
      bus.clr       = 1'b0;
      bus.load      = 1'b0;
      bus.load_val  = 24'h0;
      bus.mode_down = 1'b0;
      bus.lap_rd_en = 1'b0;
      rst_n         = 1'b0;
      step(2);
      checkOutput("rst_cnt",   S_CNT,   32'h0);
      checkOutput("rst_state", S_STATE, 32'd0);
      checkOutput("rst_done",  S_DONE,  32'd0);
      checkOutput("rst_count", S_COUNT, 32'd0);
      checkOutput("rst_empty", S_EMPTY, 32'd1);
      checkOutput("rst_full",  S_FULL,  32'd0);
      checkOutput("rst_ovf",   S_OVF,   32'd0);
      checkOutput("rst_rdata", S_RDATA, 32'h0);
      rst_n = 1'b1;
      step(1);

      // Count up: one tick per 4 cycles, stop holds prescaler mid-period.
      $display("[TB] count up and stop/resume");
      applyStimulus(C_START, 24'h0);
      checkOutput("run_state", S_STATE, 32'd1);
      step(40);
      checkOutput("run40_cnt",   S_CNT,   32'h000010);
      checkOutput("run40_state", S_STATE, 32'd1);
      step(2);
      applyStimulus(C_STOP, 24'h0);
      checkOutput("stop_state", S_STATE, 32'd2);
      checkOutput("stop_cnt",   S_CNT,   32'h000010);
      step(20);
      checkOutput("frozen_cnt",   S_CNT,   32'h000010);
      checkOutput("frozen_state", S_STATE, 32'd2);
      applyStimulus(C_START, 24'h0);
      checkOutput("resume_state", S_STATE, 32'd1);
      checkOutput("resume_cnt0",  S_CNT,   32'h000010);
      step(1);
      checkOutput("resume_cnt1",  S_CNT,   32'h000011);

      // Up wrap at end of day.
      $display("[TB] up wrap");
      applyStimulus(C_CLR, 24'h0);
      checkOutput("clr_cnt",   S_CNT,   32'h0);
      checkOutput("clr_state", S_STATE, 32'd0);
      applyStimulus(C_LOAD, 24'h235958);
      checkOutput("load_cnt",   S_CNT,   32'h235958);
      checkOutput("load_state", S_STATE, 32'd0);
      applyStimulus(C_START, 24'h0);
      step(4);
      checkOutput("wrap_cnt1", S_CNT, 32'h235959);
      step(4);
      checkOutput("wrap_cnt2", S_CNT,  32'h000000);
      checkOutput("wrap_done", S_DONE, 32'd0);
      checkOutput("wrap_state", S_STATE, 32'd1);

      // Countdown to expiry.
      $display("[TB] countdown");
      applyStimulus(C_CLR, 24'h0);
      bus.mode_down = 1'b1;
      applyStimulus(C_LOAD, 24'h000002);
      applyStimulus(C_START, 24'h0);
      step(4);
      checkOutput("down_cnt1", S_CNT, 32'h000001);
      step(4);
      checkOutput("down_cnt0",   S_CNT,   32'h000000);
      checkOutput("down_done0",  S_DONE,  32'd0);
      step(4);
      checkOutput("expire_cnt",   S_CNT,   32'h000000);
      checkOutput("expire_done",  S_DONE,  32'd1);
      checkOutput("expire_state", S_STATE, 32'd2);
      applyStimulus(C_START, 24'h0);
      checkOutput("restart_done",  S_DONE,  32'd0);
      checkOutput("restart_state", S_STATE, 32'd1);
      step(4);
      checkOutput("reexpire_done",  S_DONE,  32'd1);
      checkOutput("reexpire_state", S_STATE, 32'd2);
      applyStimulus(C_CLR, 24'h0);
      checkOutput("clr_done", S_DONE, 32'd0);
      bus.mode_down = 1'b0;

      // Lap FIFO fill, overflow, push+pop while full, drain.
      $display("[TB] lap fifo");
      applyStimulus(C_START, 24'h0);
      step(4);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(C_LAP, 24'h0);
         if (i <= 4) lap_q.push_back(24'(i));
         step(3);
      end
      checkOutput("fill_count", S_COUNT, 32'd4);
      checkOutput("fill_full",  S_FULL,  32'd1);
      checkOutput("fill_ovf",   S_OVF,   32'd1);
      checkOutput("fill_empty", S_EMPTY, 32'd0);
      checkOutput("fill_rdata", S_RDATA, 32'h000001);
      applyStimulus(C_STOP, 24'h0);
      checkOutput("lapstop_cnt", S_CNT, 32'h000006);
      applyStimulus(C_LAP | C_POP, 24'h0);
      lap_q.push_back(24'h000006);
      checkOutput("pushpop_count", S_COUNT, 32'd4);
      checkOutput("pushpop_full",  S_FULL,  32'd1);
      checkOutput("pushpop_rdata", S_RDATA, 32'h000002);
      for (int i = 0; i < 4; i++) applyStimulus(C_POP, 24'h0);
      checkOutput("drain_empty", S_EMPTY, 32'd1);
      checkOutput("drain_count", S_COUNT, 32'd0);
      checkOutput("drain_rdata", S_RDATA, 32'h0);
      checkOutput("drain_full",  S_FULL,  32'd0);
      checkOutput("drain_ovf",   S_OVF,   32'd1);
      applyStimulus(C_POP, 24'h0);
      checkOutput("emptypop_count", S_COUNT, 32'd0);
      checkOutput("emptypop_empty", S_EMPTY, 32'd1);

      // Load filtering and clr priority.
      $display("[TB] load filtering");
      applyStimulus(C_LOAD, 24'h240000);
      checkOutput("bad_hr_cnt", S_CNT, 32'h000006);
      applyStimulus(C_LOAD, 24'h006000);
      checkOutput("bad_min_cnt", S_CNT, 32'h000006);
      applyStimulus(C_LOAD, 24'h000009);
      checkOutput("stopload_cnt",   S_CNT,   32'h000009);
      checkOutput("stopload_state", S_STATE, 32'd2);
      applyStimulus(C_START, 24'h0);
      applyStimulus(C_LOAD, 24'h123456);
      checkOutput("runload_cnt",   S_CNT,   32'h000009);
      checkOutput("runload_state", S_STATE, 32'd1);
      applyStimulus(C_CLR | C_LOAD, 24'h123456);
      checkOutput("clrload_cnt",   S_CNT,   32'h0);
      checkOutput("clrload_state", S_STATE, 32'd0);
      checkOutput("clr_ovf",       S_OVF,   32'd0);

      // Asynchronous reset in the middle of a run with laps stored.
      $display("[TB] async reset");
      bus.mode_down = 1'b0;
      applyStimulus(C_START, 24'h0);
      step(4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(C_LAP, 24'h0);
         step(3);
      end
      checkOutput("pre_rst_count", S_COUNT, 32'd3);
      checkOutput("pre_rst_cnt",   S_CNT,   32'h000004);
      checkOutput("pre_rst_state", S_STATE, 32'd1);
      step(1);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_cnt",   S_CNT,   32'h0);
      checkOutput("arst_state", S_STATE, 32'd0);
      checkOutput("arst_count", S_COUNT, 32'd0);
      checkOutput("arst_empty", S_EMPTY, 32'd1);
      checkOutput("arst_ovf",   S_OVF,   32'd0);
      checkOutput("arst_rdata", S_RDATA, 32'h0);
      step(2);
      rst_n = 1'b1;
      step(1);
      checkOutput("lap_scoreboard_left", S_LAPQ, 32'd0);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
